// File: rtl/add_sub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op encodings and the result-flag bundle.
package add_sub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic carry;
        logic ovf;
        logic zero;
        logic neg;
    } add_sub_flags_t;

endpackage

// File: rtl/add_sub_slice.sv
// Combinational SLICE_W-bit ripple-carry adder built from a per-bit full-adder equation.
// Exposes the carry into the MSB so the caller can derive signed overflow.
module add_sub_slice
    import add_sub_pkg::*;
#(
    parameter int SLICE_W = 4
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               cmsb
);

    logic [SLICE_W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[SLICE_W];
    assign cmsb = c[SLICE_W-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement add/sub with one carry slice per stage and a global-stall valid/ready pipe.
// Optional ADD_SUB_SAT_EN: saturate the result on signed overflow. Requires STAGES >= 2.
module pipelined_add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);

    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic adv;

    // Per-stage inputs: stage 0 reads the ports, stage k reads the registers of stage k-1
    logic [WIDTH-1:0] src_a   [STAGES];
    logic [WIDTH-1:0] src_b   [STAGES];
    logic [WIDTH-1:0] src_sum [STAGES];
    logic [WIDTH-1:0] nxt_sum [STAGES];
    logic             src_op  [STAGES];
    logic             src_cin [STAGES];
    logic             src_vld [STAGES];
    logic [SW-1:0]    sl_a    [STAGES];
    logic [SW-1:0]    sl_b    [STAGES];
    logic [SW-1:0]    sl_sum  [STAGES];
    logic             sl_co   [STAGES];
    logic             sl_cm   [STAGES];

    logic [WIDTH-1:0] a_p   [LAST];
    logic [WIDTH-1:0] b_p   [LAST];
    logic [WIDTH-1:0] sum_p [LAST];
    logic             op_p  [LAST];
    logic             cy_p  [LAST];
    logic             vld_p [LAST];

    logic             vld_out_p;
    logic [WIDTH-1:0] res_p;
    add_sub_flags_t   flags_p;

    logic [WIDTH-1:0] res_fin;
    logic             ovf_fin;
    add_sub_flags_t   flags_fin;

    assign adv      = !vld_out_p || out_ready;
    assign in_ready = adv;

    always_comb begin
        src_a[0]   = in_a;
        src_b[0]   = in_b;
        src_op[0]  = in_op;
        src_cin[0] = (in_op == OP_SUB);
        src_sum[0] = '0;
        src_vld[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k]   = a_p[k-1];
            src_b[k]   = b_p[k-1];
            src_op[k]  = op_p[k-1];
            src_cin[k] = cy_p[k-1];
            src_sum[k] = sum_p[k-1];
            src_vld[k] = vld_p[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            sl_a[k] = src_a[k][k*SW +: SW];
            sl_b[k] = src_b[k][k*SW +: SW] ^ {SW{src_op[k] == OP_SUB}};
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        add_sub_slice #(
            .SLICE_W (SW)
        ) u_slice (
            .a    (sl_a[k]),
            .b    (sl_b[k]),
            .cin  (src_cin[k]),
            .sum  (sl_sum[k]),
            .cout (sl_co[k]),
            .cmsb (sl_cm[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt_sum[k]               = src_sum[k];
            nxt_sum[k][k*SW +: SW]   = sl_sum[k];
        end
    end

    assign ovf_fin = sl_cm[LAST] ^ sl_co[LAST];

`ifdef ADD_SUB_SAT_EN
    function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH-1:0] raw,
                                                 input logic             ovf,
                                                 input logic             a_neg);
        if (!ovf) return raw;
        return a_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    assign res_fin = sat_sum(nxt_sum[LAST], ovf_fin, src_a[LAST][WIDTH-1]);
`else
    assign res_fin = nxt_sum[LAST];
`endif

    always_comb begin
        flags_fin.carry = sl_co[LAST];
        flags_fin.ovf   = ovf_fin;
        flags_fin.zero  = (res_fin == '0);
        flags_fin.neg   = res_fin[WIDTH-1];
    end

    // Stage boundaries: valid chain and output registers (reset) -- whole pipe moves only on adv
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < LAST; k++) vld_p[k] <= 1'b0;
            vld_out_p <= 1'b0;
            res_p     <= '0;
            flags_p   <= '0;
        end else if (adv) begin
            for (int k = 0; k < LAST; k++) vld_p[k] <= src_vld[k];
            vld_out_p <= src_vld[LAST];
            res_p     <= res_fin;
            flags_p   <= flags_fin;
        end
    end

    // Stage boundaries: skew (operands, op), slice carries and de-skew partial sums
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int k = 0; k < LAST; k++) begin
                a_p[k]   <= src_a[k];
                b_p[k]   <= src_b[k];
                op_p[k]  <= src_op[k];
                cy_p[k]  <= sl_co[k];
                sum_p[k] <= nxt_sum[k];
            end
        end
    end

    assign out_valid = vld_out_p;
    assign out_sum   = res_p;
    assign out_carry = flags_p.carry;
    assign out_ovf   = flags_p.ovf;
    assign out_zero  = flags_p.zero;
    assign out_neg   = flags_p.neg;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Scoreboard bench for pipelined_add_sub (WIDTH=16, STAGES=4); honours ADD_SUB_SAT_EN when defined.
module tb_pipelined_add_sub;
    import add_sub_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_carry;
    logic        out_ovf;
    logic        out_zero;
    logic        out_neg;

    pipelined_add_sub #(
        .WIDTH  (16),
        .STAGES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .out_neg   (out_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

`ifdef ADD_SUB_SAT_EN
    localparam logic [19:0] EXP_OVF = 20'h4_7FFF;
`else
    localparam logic [19:0] EXP_OVF = 20'h5_8000;
`endif

    typedef struct {
        logic [19:0] val;
        int          cyc;
    } sb_t;

    sb_t         sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic        held  = 1'b0;
    logic        rst_prev = 1'b0;
    logic [19:0] held_val = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Packed as {carry, ovf, zero, neg, sum}
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic op);
        logic [15:0] bx;
        logic [16:0] full;
        logic [15:0] s;
        logic        c;
        logic        o;
        bx   = (op == OP_SUB) ? ~b : b;
        full = {1'b0, a} + {1'b0, bx} + {16'd0, op};
        s    = full[15:0];
        c    = full[16];
        o    = (a[15] == bx[15]) && (s[15] != a[15]);
`ifdef ADD_SUB_SAT_EN
        if (o) s = a[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {c, o, (s == 16'h0000), s[15], s};
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // One clock: drive at negedge, sample 1ns later, update the scoreboard
    task automatic step(input logic rst, input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic op, input logic rdy, input logic lat, input logic use_d,
                        input logic [19:0] dexp, output logic acc);
        sb_t         e;
        logic [19:0] cur;
        @(negedge clk);
        rst_n     = !rst;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = rdy;
        #1;
        cur = {out_carry, out_ovf, out_zero, out_neg, out_sum};
        acc = 1'b0;
        if (rst_prev)
            check("reset_state", {10'd0, out_valid, cur, in_ready}, {10'd0, 1'b0, 20'h0, 1'b1});
        if (!rst) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || rdy)});
            if (held) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_hold", {12'd0, cur}, {12'd0, held_val});
            end
            if (out_valid && rdy) begin
                if (sb.size() == 0) begin
                    check("spurious_out", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", {12'd0, cur}, {12'd0, e.val});
                    if (lat) check("latency", cyc - e.cyc, 32'd4);
                end
            end
            if (v && in_ready) begin
                acc   = 1'b1;
                e.val = use_d ? dexp : model(a, b, op);
                e.cyc = cyc;
                sb.push_back(e);
            end
            held     = out_valid && !rdy;
            held_val = cur;
        end else begin
            sb.delete();
            held = 1'b0;
        end
        rst_prev = rst;
        cyc++;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic op,
                        input logic use_d, input logic [19:0] dexp);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            step(1'b0, 1'b1, a, b, op, 1'b1, 1'b1, use_d, dexp, acc);
            tries++;
        end
        check("send_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic idle(input int n, input logic lat);
        logic acc;
        repeat (n) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, lat, 1'b0, 20'h0, acc);
    endtask

    task automatic drain(input logic lat);
        logic acc;
        for (int i = 0; i < 100 && sb.size() != 0; i++)
            step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, lat, 1'b0, 20'h0, acc);
        idle(2, lat);
        check("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        logic        acc;
        int          sent;
        logic        rv;
        logic        rr;
        logic        rop;
        logic [15:0] ra;
        logic [15:0] rb;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = 1'b0;
        out_ready = 1'b0;

        step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h0, acc);
        step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h0, acc);

        // Directed corner cases, back to back with the output always ready
        send(16'h1234, 16'h0001, OP_ADD, 1'b1, 20'h0_1235);
        send(16'h0005, 16'h0007, OP_SUB, 1'b1, 20'h1_FFFE);
        send(16'h7FFF, 16'h0001, OP_ADD, 1'b1, EXP_OVF);
        send(16'h8000, 16'h8000, OP_SUB, 1'b1, 20'hA_0000);
        send(16'hFFFF, 16'h0001, OP_ADD, 1'b1, 20'hA_0000);
        drain(1'b1);

        // Random traffic with occasional bubbles and a pseudo-random stalling sink
        sent = 0;
        for (int i = 0; i < 3000 && sent < 100; i++) begin
            rv  = ($urandom_range(0, 7) != 0);
            rr  = ($urandom_range(0, 2) != 0);
            rop = 1'($urandom_range(0, 1));
            ra  = pick();
            rb  = pick();
            step(1'b0, rv, ra, rb, rop, rr, 1'b0, 1'b0, 20'h0, acc);
            if (acc) sent++;
        end
        check("rand_sent", sent, 32'd100);
        drain(1'b0);

        // Reset with three beats in flight, then a fresh beat
        send(16'h1111, 16'h2222, OP_ADD, 1'b0, 20'h0);
        send(16'h3333, 16'h0001, OP_SUB, 1'b0, 20'h0);
        send(16'h7FFF, 16'h7FFF, OP_ADD, 1'b0, 20'h0);
        step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h0, acc);
        idle(8, 1'b1);
        send(16'h0100, 16'h0023, OP_ADD, 1'b1, 20'h0_0123);
        drain(1'b1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
